tick_level_encoder: RTL and testbench
=====================================

# tick_level_encoder

Transmit-side partner of the strobe-sampled edge detector: converts one-clock request ticks into a level waveform on `level` that a detector sampling on the same `update` strobe recovers as exactly one rising edge per request. Each request produces a high phase of a fixed number of update samples, followed by a guaranteed low gap. Requests that arrive while a pulse is in flight are queued in a saturating pending counter. The block sits between tick-producing control logic and any level-sampling consumer on the shared update strobe.

## Interface
- `HIGH_SAMPLES`, default 2: update steps `level` is held high per request; legal range 1..255.
- `LOW_SAMPLES`, default 2: minimum update steps `level` is held low between pulses; legal range 1..255.
- `PEND_W`, default 4: width of the pending-request counter; saturates at 2^PEND_W-1.
- `clk` in 1: single clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-low; clears all state immediately on assertion.
- `update` in 1: sample strobe; one "step" per rising edge, detected in `clk` domain.
- `tick_in` in 1: request pulse; each high clock is one request.
- `level` out 1: encoded level; registered Moore output.
- `busy` out 1: high while state != IDLE or pending != 0.
- `pending` out PEND_W: queued, not-yet-started requests.
- `overflow` out 1: one-clock pulse when a request is dropped.

## Operation
- Step detect: `update_prev` register; step = `update`==1 && `update_prev`==0. `update_prev` resets to 0, so `update` already high at reset release yields one step.
- States: IDLE (`level`=0), HIGH (`level`=1), GAP (`level`=0). `level`=1 iff state==HIGH. An 8-bit step counter `cnt` runs within HIGH/GAP.
- IDLE: on step with `pending`>0 -> HIGH, `cnt`=1, consume one request. Otherwise stay.
- HIGH: on step, if `cnt`==HIGH_SAMPLES -> GAP, `cnt`=1; else `cnt`+1.
- GAP: on step, if `cnt`!=LOW_SAMPLES -> `cnt`+1. If `cnt`==LOW_SAMPLES and `pending`>0 -> HIGH, `cnt`=1, consume. If `cnt`==LOW_SAMPLES and `pending`==0 -> IDLE.
- No state or `cnt` change without a step.
- Pending counter:
  - `tick_in` alone: +1.
  - Consume alone: -1.
  - Both in the same cycle: unchanged.
  - Consume decisions use the registered `pending` value, so a `tick_in` in the same cycle is not itself consumed.
- Saturation: `tick_in` while `pending`==max and no consume that cycle -> `pending` stays max, `overflow`=1 for the following clock. If a consume coincides, no overflow.
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - state=IDLE, `cnt`=0, `pending`=0, `update_prev`=0.
  - `level`=0, `busy`=0, `overflow`=0.
  - An in-flight pulse is abandoned and never resumed.

## Timing
- `tick_in` at edge t: visible in `pending` after edge t.
- IDLE with `pending`>0: `level` rises after the clock edge that detects the step (same edge that updates `update_prev`).
- Pulse width: exactly HIGH_SAMPLES steps. Gap: exactly LOW_SAMPLES steps when back-to-back; at least LOW_SAMPLES steps otherwise.
- A detector sampling `level` on the same steps sees one 0->1 transition per request, provided HIGH_SAMPLES>=1 and LOW_SAMPLES>=1.
- `busy` and `overflow` are registered; `busy` falls in the same cycle the state enters IDLE with `pending`==0.

## Test plan
- Reset mid-pulse: assert `reset`=0 while in HIGH with `pending`=3 -> `level`, `busy` and `pending` go to 0 without waiting for a clock edge; no pulse after release until a new `tick_in`.
- Single request, `update` toggled 1-high/3-low (step every 4 clocks), defaults: one `tick_in` -> `level` high for 8 clocks (2 steps), then low; `pending` 1->0; `busy` clears after 2 GAP steps.
- Three consecutive `tick_in` clocks: `pending` reaches 3, then three pulses, each 2 steps high, separated by exactly 2 low steps; `pending` counts 2,1,0; state ends in IDLE.
- `update` held high for 20 clocks after one tick: exactly one step occurs; state advances once (IDLE->HIGH) and holds.
- Saturation with `PEND_W`=4 and no steps: 16 ticks -> `pending`=15, one `overflow` pulse on the 16th. Then `tick_in` coincident with an IDLE consume step -> `pending` stays 15, no `overflow`.
- `tick_in` on the same cycle as a step in IDLE with `pending`=0 -> no pulse on that step; `level` rises on the next step.

Source files
------------

// File: rtl/tick_level_encoder.sv
// tick_level_encoder: turns one-clock request ticks into a level waveform.
// Each request becomes a high phase of HIGH_SAMPLES update steps followed by
// a low gap of at least LOW_SAMPLES steps. Requests arriving mid-pulse are
// queued in a saturating pending counter.
module tick_level_encoder #(
  parameter int HIGH_SAMPLES = 2,
  parameter int LOW_SAMPLES  = 2,
  parameter int PEND_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic              tick_in,
  output logic              level,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [7:0]        HIGH_LAST = 8'(HIGH_SAMPLES);
  localparam logic [7:0]        LOW_LAST  = 8'(LOW_SAMPLES);

  state_t            state;
  state_t            state_next;
  logic [7:0]        cnt;
  logic [7:0]        cnt_next;
  logic              update_prev;
  logic              step;
  logic              consume;
  logic [PEND_W-1:0] pending_next;
  logic              overflow_next;

  // A step is a rising edge of the update strobe seen in the clk domain.
  always_comb begin
    step = update && !update_prev;
  end

  // Next-state logic; state and cnt only move on a step, and a new pulse
  // consumes one queued request based on the registered pending value.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    consume    = 1'b0;
    if (step) begin
      case (state)
        IDLE: begin
          if (pending != '0) begin
            state_next = HIGH;
            cnt_next   = 8'd1;
            consume    = 1'b1;
          end
        end
        HIGH: begin
          if (cnt == HIGH_LAST) begin
            state_next = GAP;
            cnt_next   = 8'd1;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
        GAP: begin
          if (cnt != LOW_LAST) begin
            cnt_next = cnt + 8'd1;
          end else if (pending != '0) begin
            state_next = HIGH;
            cnt_next   = 8'd1;
            consume    = 1'b1;
          end else begin
            state_next = IDLE;
            cnt_next   = 8'd0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end
      endcase
    end
  end

  // Pending counter: a tick and a consume in the same cycle cancel; a tick
  // with nowhere to go at saturation is dropped and flagged.
  always_comb begin
    pending_next  = pending;
    overflow_next = 1'b0;
    if (tick_in && !consume) begin
      if (pending == PEND_MAX) begin
        overflow_next = 1'b1;
      end else begin
        pending_next = pending + PEND_W'(1);
      end
    end else if (consume && !tick_in) begin
      pending_next = pending - PEND_W'(1);
    end
  end

  // State register with registered Moore outputs derived from next values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      update_prev <= 1'b0;
      pending     <= '0;
      overflow    <= 1'b0;
      level       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      update_prev <= update;
      pending     <= pending_next;
      overflow    <= overflow_next;
      level       <= (state_next == HIGH);
      busy        <= (state_next != IDLE) || (pending_next != '0);
    end
  end

endmodule

// File: tb/tb_tick_level_encoder.sv
// Testbench for tick_level_encoder: directed scenarios with literal
// expectations plus randomized traffic checked against a step-count model.
module tb_tick_level_encoder;

  localparam int HS    = 2;
  localparam int LS    = 2;
  localparam int PW    = 4;
  localparam int PMAX  = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          updateIn = 1'b0;
  logic          tickIn = 1'b0;
  logic          level;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  int  mPending = 0;
  int  highLeft = 0;
  int  gapLeft = 0;
  bit  mOverflow = 1'b0;
  bit  mUpdPrev = 1'b0;
  bit  mStep = 1'b0;
  bit  mTook = 1'b0;

  int  risingCount = 0;
  int  highClocks = 0;
  int  ovCount = 0;
  bit  prevLevel = 1'b0;

  tick_level_encoder #(
    .HIGH_SAMPLES(HS),
    .LOW_SAMPLES (LS),
    .PEND_W      (PW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .update  (updateIn),
    .tick_in (tickIn),
    .level   (level),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model: counts remaining high/gap steps of the current pulse
  // and the queue of requests not yet started.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mPending  = 0;
      highLeft  = 0;
      gapLeft   = 0;
      mOverflow = 1'b0;
      mUpdPrev  = 1'b0;
    end else begin
      mStep    = updateIn && !mUpdPrev;
      mUpdPrev = updateIn;
      mTook    = 1'b0;
      if (mStep) begin
        if (highLeft > 0) begin
          highLeft--;
          if (highLeft == 0) gapLeft = LS;
        end else if (gapLeft > 0) begin
          gapLeft--;
          if (gapLeft == 0 && mPending > 0) begin
            highLeft = HS;
            mTook    = 1'b1;
          end
        end else if (mPending > 0) begin
          highLeft = HS;
          mTook    = 1'b1;
        end
      end
      mOverflow = 1'b0;
      if (tickIn && !mTook) begin
        if (mPending == PMAX) mOverflow = 1'b1;
        else mPending++;
      end else if (mTook && !tickIn) begin
        mPending--;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit t, input bit u);
    @(negedge clk);
    tickIn   = t;
    updateIn = u;
  endtask

  task automatic sampleAfterEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset    = 1'b0;
    tickIn   = 1'b0;
    updateIn = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic runPattern(input int nClocks);
    for (int i = 0; i < nClocks; i++) applyStimulus(1'b0, (i % 4) == 0);
  endtask

  task automatic waitIdle(input string name, input int maxClocks);
    int n;
    n = 0;
    while (busy && n < maxClocks) begin
      applyStimulus(1'b0, (n % 4) == 0);
      n++;
    end
    checkOutput(name, int'(busy), 0);
  endtask

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("level", int'(level), int'(highLeft > 0));
      checkOutput("busy", int'(busy), int'(highLeft > 0 || gapLeft > 0 || mPending > 0));
      checkOutput("pending", int'(pending), mPending);
      checkOutput("overflow", int'(overflow), int'(mOverflow));
    end
  end

  // Event counters for literal expectations in the directed tests.
  always @(negedge clk) begin
    if (level && !prevLevel) risingCount++;
    if (level) highClocks++;
    if (overflow) ovCount++;
    prevLevel = level;
  end

  initial begin
    int rise0;
    repeat (2) @(negedge clk);
    checkOn = 1'b1;
    checkOutput("reset_level", int'(level), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_pending", int'(pending), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    reset = 1'b1;

    // Single request with a step every 4 clocks.
    risingCount = 0; highClocks = 0;
    applyStimulus(1'b1, 1'b0);
    sampleAfterEdge();
    checkOutput("single_pending_after_tick", int'(pending), 1);
    runPattern(24);
    sampleAfterEdge();
    checkOutput("single_high_clocks", highClocks, 8);
    checkOutput("single_rises", risingCount, 1);
    checkOutput("single_busy_end", int'(busy), 0);
    checkOutput("single_pending_end", int'(pending), 0);

    // Three back-to-back requests.
    risingCount = 0; highClocks = 0;
    repeat (3) applyStimulus(1'b1, 1'b0);
    sampleAfterEdge();
    checkOutput("three_pending", int'(pending), 3);
    waitIdle("three_idle_timeout", 200);
    checkOutput("three_rises", risingCount, 3);
    checkOutput("three_high_clocks", highClocks, 24);

    // Update held high gives one step only.
    risingCount = 0;
    applyStimulus(1'b1, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b1);
    sampleAfterEdge();
    checkOutput("held_level", int'(level), 1);
    checkOutput("held_pending", int'(pending), 0);
    checkOutput("held_rises", risingCount, 1);
    applyStimulus(1'b0, 1'b0);
    waitIdle("held_idle_timeout", 100);

    // Saturation without steps, then a tick coinciding with a consume.
    doReset();
    ovCount = 0;
    repeat (16) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    sampleAfterEdge();
    checkOutput("sat_pending", int'(pending), 15);
    checkOutput("sat_overflow_pulses", ovCount, 1);
    applyStimulus(1'b1, 1'b1);
    sampleAfterEdge();
    checkOutput("sat_consume_pending", int'(pending), 15);
    checkOutput("sat_consume_overflow", int'(overflow), 0);
    checkOutput("sat_consume_level", int'(level), 1);

    // Tick coinciding with a step in IDLE while nothing is queued.
    doReset();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    sampleAfterEdge();
    checkOutput("coinc_level_low", int'(level), 0);
    checkOutput("coinc_pending", int'(pending), 1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    sampleAfterEdge();
    checkOutput("coinc_level_next_step", int'(level), 1);
    checkOutput("coinc_pending_after", int'(pending), 0);

    // Asynchronous reset in the middle of a pulse with requests queued.
    doReset();
    repeat (4) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    sampleAfterEdge();
    checkOutput("midrst_pre_level", int'(level), 1);
    checkOutput("midrst_pre_pending", int'(pending), 3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_level", int'(level), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_pending", int'(pending), 0);
    @(negedge clk);
    tickIn = 1'b0; updateIn = 1'b0;
    reset = 1'b1;
    rise0 = risingCount;
    runPattern(40);
    sampleAfterEdge();
    checkOutput("midrst_no_resume", risingCount - rise0, 0);

    // Randomized traffic with occasional bursts and resets.
    for (int i = 0; i < 4000; i++) begin
      bit t;
      bit u;
      if ((i / 500) % 2 == 1) t = ($urandom_range(0, 1) == 0);
      else t = ($urandom_range(0, 7) == 0);
      u = ($urandom_range(0, 2) == 0) ? ~updateIn : updateIn;
      applyStimulus(t, u);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    applyStimulus(1'b0, 1'b0);
    waitIdle("random_drain_timeout", 2000);
    sampleAfterEdge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
